// File: rtl/if_fetch_if.sv
// Instruction-memory request bus between the fetch stage and the memory.
// One outstanding request at a time. The request is accepted by gnt, and the
// word returns later on rvalid/rdata.
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // Fetch-stage side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage.
// Owns the fetch PC and issues one request at a time on the imem bus. Each
// returned word is presented to the IF/ID register together with the address
// it was fetched from. A one-entry skid buffer catches a word that returns
// while the downstream stage is holding. A redirect flushes everything and
// restarts fetch at the new address. A fetch that is already in flight when
// the redirect arrives is squashed when it returns.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pc_stall,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    if_fetch_if.master   imem,
    output logic [31:0]  IF_pc,
    output logic [31:0]  IF_pc4,
    output logic [31:0]  IF_inst,
    output logic         IF_have_inst
);

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;      // address of the fetch in flight

    logic        skid_vld_q, skid_vld_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;

    logic        out_vld_q, out_vld_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pc4_q, out_pc4_d;
    logic [31:0] out_inst_q, out_inst_d;

    logic [31:0] redirect_pc_aligned;
    logic        slot_free;
    logic        rdata_take;

    // The low two bits of the redirect target are dropped to keep fetch word aligned.
    assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;
    // The output slot can take a new word if it is empty or is being consumed.
    assign slot_free  = !out_vld_q || !pc_stall;
    // Returned data counts only in WAIT. In DROP it is squashed, and anywhere else it is a protocol error.
    assign rdata_take = imem.imem_rvalid && (state_q == ST_WAIT) && !redirect;

    // Fetch FSM: next state, fetch PC and request outputs
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        req_pc_d       = req_pc_q;
        imem.imem_req  = (state_q == ST_REQ);
        imem.imem_addr = fetch_pc_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc_aligned;
            case (state_q)
                ST_REQ:  state_d = imem.imem_gnt ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = imem.imem_rvalid ? ST_REQ : ST_DROP;
                ST_HOLD: state_d = ST_REQ;
                ST_DROP: state_d = imem.imem_rvalid ? ST_REQ : ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_RST: state_d = ST_REQ;
                ST_REQ: begin
                    if (imem.imem_gnt) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_rvalid) begin
                        state_d = slot_free ? ST_REQ : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!pc_stall) begin
                        state_d = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem.imem_rvalid) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_RST;
            endcase
        end
    end

    // Output slot and skid buffer: the skid buffer loads first, then returning data
    always_comb begin
        skid_vld_d  = skid_vld_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        out_vld_d   = out_vld_q;
        out_pc_d    = out_pc_q;
        out_pc4_d   = out_pc4_q;
        out_inst_d  = out_inst_q;

        if (redirect) begin
            skid_vld_d = 1'b0;
            out_vld_d  = 1'b0;
            out_pc_d   = 32'd0;
            out_pc4_d  = 32'd0;
            out_inst_d = 32'd0;
        end else if (slot_free) begin
            if (skid_vld_q) begin
                skid_vld_d = 1'b0;
                out_vld_d  = 1'b1;
                out_pc_d   = skid_pc_q;
                out_pc4_d  = skid_pc_q + 32'd4;
                out_inst_d = skid_inst_q;
            end else if (rdata_take) begin
                out_vld_d  = 1'b1;
                out_pc_d   = req_pc_q;
                out_pc4_d  = req_pc_q + 32'd4;
                out_inst_d = imem.imem_rdata;
            end else begin
                out_vld_d  = 1'b0;
            end
        end else if (rdata_take) begin
            skid_vld_d  = 1'b1;
            skid_pc_d   = req_pc_q;
            skid_inst_d = imem.imem_rdata;
        end
    end

    // State, PC, skid and output-slot registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RST;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= 32'd0;
            skid_vld_q  <= 1'b0;
            skid_pc_q   <= 32'd0;
            skid_inst_q <= 32'd0;
            out_vld_q   <= 1'b0;
            out_pc_q    <= 32'd0;
            out_pc4_q   <= 32'd0;
            out_inst_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            skid_vld_q  <= skid_vld_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            out_vld_q   <= out_vld_d;
            out_pc_q    <= out_pc_d;
            out_pc4_q   <= out_pc4_d;
            out_inst_q  <= out_inst_d;
        end
    end

    assign IF_pc        = out_pc_q;
    assign IF_pc4       = out_pc4_q;
    assign IF_inst      = out_inst_q;
    assign IF_have_inst = out_vld_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch. Each table row holds the inputs for one clock
// cycle and the outputs expected during that cycle, before its closing edge.
// Hand-written sequences at the end cover asynchronous reset in the middle of
// a fetch.
module tb_if_fetch;

    localparam logic [31:0] XK = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        pc_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] IF_pc, IF_pc4, IF_inst;
    logic        IF_have_inst;

    if_fetch_if imem_bus ();

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_stall     (pc_stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem         (imem_bus),
        .IF_pc        (IF_pc),
        .IF_pc4       (IF_pc4),
        .IF_inst      (IF_inst),
        .IF_have_inst (IF_have_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        have;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } vec_t;

    localparam int NV = 42;
    vec_t vecs [NV];

    int n_cmp;
    int n_bad;
    int row;

    function automatic logic [31:0] dw(input logic [31:0] a);
        return a ^ XK;
    endfunction

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic g, input logic rv, input logic [31:0] rdat,
                                input logic rq, input logic [31:0] ad, input logic hv,
                                input logic [31:0] p, input logic [31:0] p4,
                                input logic [31:0] ins);
        vec_t v;
        v.stall = st; v.redir = rd; v.rpc = rpc; v.gnt = g; v.rv = rv; v.rdata = rdat;
        v.req = rq; v.addr = ad; v.have = hv; v.pc = p; v.pc4 = p4; v.inst = ins;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic check_all(input logic rq, input logic [31:0] ad, input logic hv,
                             input logic [31:0] p, input logic [31:0] p4,
                             input logic [31:0] ins);
        check("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, rq});
        check("imem_addr", imem_bus.imem_addr, ad);
        check("IF_have_inst", {31'd0, IF_have_inst}, {31'd0, hv});
        check("IF_pc", IF_pc, p);
        check("IF_pc4", IF_pc4, p4);
        check("IF_inst", IF_inst, ins);
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic g, input logic rv, input logic [31:0] rdat);
        pc_stall             = st;
        redirect             = rd;
        redirect_pc          = rpc;
        imem_bus.imem_gnt    = g;
        imem_bus.imem_rvalid = rv;
        imem_bus.imem_rdata  = rdat;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        row   = -1;
        rst   = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // zero-wait fetches of 0 and 4, then no gnt for 3 cycles at 0x8
        vecs[0]  = mk(0,0,0,         0,0,0,            0,32'h0,  0,32'h0,  32'h0,  32'h0);
        vecs[1]  = mk(0,0,0,         1,0,0,            1,32'h0,  0,32'h0,  32'h0,  32'h0);
        vecs[2]  = mk(0,0,0,         0,1,dw(32'h0),    0,32'h4,  0,32'h0,  32'h0,  32'h0);
        vecs[3]  = mk(0,0,0,         1,0,0,            1,32'h4,  1,32'h0,  32'h4,  dw(32'h0));
        vecs[4]  = mk(0,0,0,         0,1,dw(32'h4),    0,32'h8,  0,32'h0,  32'h4,  dw(32'h0));
        vecs[5]  = mk(0,0,0,         0,0,0,            1,32'h8,  1,32'h4,  32'h8,  dw(32'h4));
        vecs[6]  = mk(0,0,0,         0,0,0,            1,32'h8,  0,32'h4,  32'h8,  dw(32'h4));
        vecs[7]  = mk(0,0,0,         0,0,0,            1,32'h8,  0,32'h4,  32'h8,  dw(32'h4));
        vecs[8]  = mk(0,0,0,         1,0,0,            1,32'h8,  0,32'h4,  32'h8,  dw(32'h4));
        vecs[9]  = mk(0,0,0,         0,1,dw(32'h8),    0,32'hC,  0,32'h4,  32'h8,  dw(32'h4));
        vecs[10] = mk(0,0,0,         1,0,0,            1,32'hC,  1,32'h8,  32'hC,  dw(32'h8));
        vecs[11] = mk(0,0,0,         0,1,dw(32'hC),    0,32'h10, 0,32'h8,  32'hC,  dw(32'h8));
        vecs[12] = mk(0,0,0,         1,0,0,            1,32'h10, 1,32'hC,  32'h10, dw(32'hC));
        vecs[13] = mk(0,0,0,         0,1,dw(32'h10),   0,32'h14, 0,32'hC,  32'h10, dw(32'hC));
        // 5-cycle stall on 0x10; 0x14 parks in the skid buffer; a stray rvalid in HOLD is ignored
        vecs[14] = mk(1,0,0,         1,0,0,            1,32'h14, 1,32'h10, 32'h14, dw(32'h10));
        vecs[15] = mk(1,0,0,         0,1,dw(32'h14),   0,32'h18, 1,32'h10, 32'h14, dw(32'h10));
        vecs[16] = mk(1,0,0,         0,1,32'hDEAD0000, 0,32'h18, 1,32'h10, 32'h14, dw(32'h10));
        vecs[17] = mk(1,0,0,         0,0,0,            0,32'h18, 1,32'h10, 32'h14, dw(32'h10));
        vecs[18] = mk(1,0,0,         0,0,0,            0,32'h18, 1,32'h10, 32'h14, dw(32'h10));
        vecs[19] = mk(0,0,0,         0,0,0,            0,32'h18, 1,32'h10, 32'h14, dw(32'h10));
        vecs[20] = mk(0,0,0,         1,0,0,            1,32'h18, 1,32'h14, 32'h18, dw(32'h14));
        vecs[21] = mk(0,0,0,         0,0,0,            0,32'h1C, 0,32'h14, 32'h18, dw(32'h14));
        // redirect to 0x102 in WAIT; late rvalid squashed in DROP
        vecs[22] = mk(0,1,32'h102,   0,0,0,            0,32'h1C, 0,32'h14, 32'h18, dw(32'h14));
        vecs[23] = mk(0,0,0,         0,0,0,            0,32'h100,0,32'h0,  32'h0,  32'h0);
        vecs[24] = mk(0,0,0,         0,1,dw(32'h1C),   0,32'h100,0,32'h0,  32'h0,  32'h0);
        vecs[25] = mk(0,0,0,         1,0,0,            1,32'h100,0,32'h0,  32'h0,  32'h0);
        vecs[26] = mk(0,0,0,         0,1,dw(32'h100),  0,32'h104,0,32'h0,  32'h0,  32'h0);
        vecs[27] = mk(0,0,0,         0,1,32'h00000BAD, 1,32'h104,1,32'h100,32'h104,dw(32'h100));
        vecs[28] = mk(0,0,0,         1,0,0,            1,32'h104,0,32'h100,32'h104,dw(32'h100));
        // redirect coincident with rvalid
        vecs[29] = mk(0,1,32'h200,   0,1,dw(32'h104),  0,32'h108,0,32'h100,32'h104,dw(32'h100));
        vecs[30] = mk(0,0,0,         1,0,0,            1,32'h200,0,32'h0,  32'h0,  32'h0);
        vecs[31] = mk(0,0,0,         0,1,dw(32'h200),  0,32'h204,0,32'h0,  32'h0,  32'h0);
        // redirect with pc_stall=1 and a valid slot
        vecs[32] = mk(1,1,32'h300,   0,0,0,            1,32'h204,1,32'h200,32'h204,dw(32'h200));
        vecs[33] = mk(0,0,0,         1,0,0,            1,32'h300,0,32'h0,  32'h0,  32'h0);
        vecs[34] = mk(0,0,0,         0,1,dw(32'h300),  0,32'h304,0,32'h0,  32'h0,  32'h0);
        vecs[35] = mk(0,0,0,         0,0,0,            1,32'h304,1,32'h300,32'h304,dw(32'h300));
        // redirect with gnt in REQ -> DROP; target 0xFFFFFFFF aligns to FFFFFFFC and wraps
        vecs[36] = mk(0,1,32'hFFFFFFFF,1,0,0,          1,32'h304,0,32'h300,32'h304,dw(32'h300));
        vecs[37] = mk(0,0,0,         0,1,dw(32'h304),  0,32'hFFFFFFFC,0,32'h0,32'h0,32'h0);
        vecs[38] = mk(0,0,0,         1,0,0,            1,32'hFFFFFFFC,0,32'h0,32'h0,32'h0);
        vecs[39] = mk(0,0,0,         0,1,dw(32'hFFFFFFFC),0,32'h0,0,32'h0,  32'h0,  32'h0);
        vecs[40] = mk(0,0,0,         0,0,0,            1,32'h0,  1,32'hFFFFFFFC,32'h0,dw(32'hFFFFFFFC));
        vecs[41] = mk(0,0,0,         1,0,0,            1,32'h0,  0,32'hFFFFFFFC,32'h0,dw(32'hFFFFFFFC));

        // reset state while rst is held low
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all(0, 32'h0, 0, 32'h0, 32'h0, 32'h0);

        // release reset; row 0 is the RST cycle
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NV; i++) begin
            row = i;
            drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc,
                  vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            #1;
            check_all(vecs[i].req, vecs[i].addr, vecs[i].have,
                      vecs[i].pc, vecs[i].pc4, vecs[i].inst);
            @(negedge clk);
        end

        // in WAIT for 0x0: asynchronous reset mid-cycle clears everything at once
        row = 100;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("wait_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check("wait_addr", imem_bus.imem_addr, 32'h4);
        rst = 1'b0;
        #1;
        check_all(0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        row = 101;
        #1;
        check_all(0, 32'h0, 0, 32'h0, 32'h0, 32'h0);

        // release with the stale rvalid in the RST cycle; it must be ignored
        row = 102;
        rst = 1'b1;
        drive(0, 0, 0, 0, 1, 32'h12345678);
        #1;
        check_all(0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        row = 103;
        drive(0, 0, 0, 1, 0, 0);
        #1;
        check_all(1, 32'h0, 0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        row = 104;
        drive(0, 0, 0, 0, 1, dw(32'h0));
        #1;
        check_all(0, 32'h4, 0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        row = 105;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_all(1, 32'h4, 1, 32'h0, 32'h4, dw(32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the fetch PC and drives the instruction-memory request interface.
- Presents {IF_pc, IF_pc4, IF_inst, IF_have_inst} to the IF/ID pipeline register directly downstream.
- Handles downstream hold (pc_stall), branch/jump redirect, and squashing of in-flight fetches.
- Memory accepts one outstanding request at a time.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
pc_stall  in  1  downstream hold; the output slot is not consumed on this edge.
redirect  in  1  taken branch/jump; flushes the fetch stage.
redirect_pc  in  32  new fetch address; bits [1:0] forced to 0.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address, word aligned.
imem_gnt  in  1  request accepted this cycle.
imem_rvalid  in  1  read data valid.
imem_rdata  in  32  instruction word.
IF_pc  out  32  PC of the presented instruction.
IF_pc4  out  32  IF_pc + 4, modulo 2^32.
IF_inst  out  32  presented instruction.
IF_have_inst  out  1  output slot holds a valid instruction.

Behaviour:
- Reset (rst=0, async):
  - State RST; fetch_pc=RESET_PC; imem_req=0; skid buffer empty.
  - IF_pc, IF_pc4, IF_inst all 0; IF_have_inst=0.
- States: RST, REQ, WAIT, HOLD, DROP.
  - RST: first edge after reset release goes to REQ. No request in RST.
  - REQ: imem_req=1, imem_addr=fetch_pc. On gnt: fetch_pc += 4 (wraps FFFF_FFFC to 0000_0000), go to WAIT. Without gnt: stay, address stable.
  - WAIT: imem_req=0. On rvalid, route the word as below. If it went to the output slot, go to REQ; if it went to the skid buffer, go to HOLD.
  - HOLD: imem_req=0. On the first edge with pc_stall=0, the buffer moves to the output slot, then go to REQ.
  - DROP: imem_req=0. The next rvalid is discarded, then go to REQ.
- Output slot, evaluated on every edge:
  - pc_stall=0 consumes the current slot contents.
  - Load order into the freed or empty slot: skid buffer first, then returning rdata.
  - A returning word with no free slot goes to the 1-entry skid buffer.
  - Nothing loaded: IF_have_inst<=0.
  - pc_stall=1: all IF_* outputs hold their values.
- Every loaded instruction carries the address it was fetched from: IF_pc = that address, IF_pc4 = address + 4.
- Redirect has highest priority, overriding pc_stall and rvalid:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - IF_have_inst <= 0; skid buffer cleared; IF_pc, IF_pc4, IF_inst <= 0.
  - Next state by current state:
    - REQ with gnt the same cycle: DROP.
    - REQ without gnt: REQ, new address next cycle; the memory tolerates the address change without gnt.
    - WAIT without rvalid: DROP.
    - WAIT with rvalid the same cycle: data discarded, go to REQ.
    - HOLD: REQ.
    - DROP: stays DROP unless rvalid arrives the same cycle, in which case REQ.
    - RST: REQ.
- Latency with zero-wait memory (gnt with req, rvalid one cycle later):
  - Request at cycle N, rvalid at N+1, IF_have_inst=1 from the edge ending N+1.
  - Throughput is one instruction per 2 cycles.
- Invariants:
  - At most one outstanding request.
  - imem_req=0 in WAIT, HOLD and DROP.
  - No instruction is duplicated or lost except by redirect.
  - rvalid outside WAIT/DROP is a protocol error and is ignored.

Test Plan:
1. Reset release, zero-wait memory returning rdata=addr^32'hA5A5_0000 → imem_addr 0,4,8,… every 2 cycles; IF_pc=0/IF_pc4=4/IF_inst=32'hA5A5_0000, then IF_pc=4/IF_inst=32'hA5A5_0004, each IF_have_inst pulse 1 cycle.
2. Hold imem_gnt=0 for 3 cycles at addr 0x8 → imem_req and imem_addr=0x8 stable for 4 cycles; fetch_pc advances only after gnt.
3. Raise pc_stall for 5 cycles while an instruction at 0x10 is presented and the fetch of 0x14 returns → slot holds 0x10; 0x14 parked in the skid buffer, no new request. On release, 0x14 is presented next cycle, then the request for 0x18 issues.
4. Redirect to 0x0000_0102 while in WAIT, with rvalid two cycles later → that rdata is discarded; next imem_addr=0x100; IF_have_inst=0 until the 0x100 data arrives.
5. Redirect coincident with rvalid, and separately with pc_stall=1 → data dropped, slot cleared, next request at redirect_pc.
6. Assert rst low mid-WAIT → all outputs zero asynchronously; after release, the first request is at RESET_PC and the stale rvalid is ignored; fetch_pc=0xFFFF_FFFC wraps to IF_pc4=0.
